instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 125 ++++++++++++
 tb/tb_instr_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Packs upsampler field sets into instruction words and writes them to instruction memory.
// Optional even-parity MSB on im_wdata when INSTR_LOADER_PARITY_EN is defined.
module instr_loader #(
  parameter int VIDWIDTH = 3,
  parameter int RFAWIDTH = 4,
  parameter int DAWIDTH  = 8,
  parameter int IAWIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                lstg_f,
  input  logic                upse_f,
  input  logic [VIDWIDTH-1:0] vector_id,
  input  logic [RFAWIDTH-1:0] result_reg,
  input  logic [RFAWIDTH-1:0] error_reg,
  input  logic [DAWIDTH-1:0]  data_uptr,
  input  logic [DAWIDTH-1:0]  data_lptr,
  input  logic [DAWIDTH-1:0]  coef_ptr,
  output logic                im_we,
  output logic [IAWIDTH-1:0]  im_addr,
`ifdef INSTR_LOADER_PARITY_EN
  output logic [2+VIDWIDTH+2*RFAWIDTH+3*DAWIDTH:0]   im_wdata,
`else
  output logic [1+VIDWIDTH+2*RFAWIDTH+3*DAWIDTH:0]   im_wdata,
`endif
  output logic                done,
  output logic                err,
  output logic [IAWIDTH:0]    prog_len
);

  localparam int INSTRWIDTH = 2 + VIDWIDTH + 2*RFAWIDTH + 3*DAWIDTH;
`ifdef INSTR_LOADER_PARITY_EN
  localparam int WDW = INSTRWIDTH + 1;
`else
  localparam int WDW = INSTRWIDTH;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t             state_q, state_d;
  logic [IAWIDTH-1:0] cnt_q, cnt_d;
  logic [IAWIDTH:0]   prog_len_q, prog_len_d;
  logic               im_we_q, im_we_d;
  logic [IAWIDTH-1:0] im_addr_q, im_addr_d;
  logic [WDW-1:0]     im_wdata_q, im_wdata_d;

  logic [INSTRWIDTH-1:0] word;
  logic [WDW-1:0]        word_out;
  logic                  xfer, term, last_slot;

  assign word = {lstg_f, upse_f, vector_id, result_reg, error_reg,
                 data_uptr, data_lptr, coef_ptr};

`ifdef INSTR_LOADER_PARITY_EN
  assign word_out = {^word, word};
`else
  assign word_out = word;
`endif

  assign xfer      = (state_q == LOAD) && in_valid;
  assign term      = lstg_f && upse_f;
  assign last_slot = &cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prog_len_d = prog_len_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d    = LOAD;
          cnt_d      = '0;
          prog_len_d = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          im_we_d    = 1'b1;
          im_addr_d  = cnt_q;
          im_wdata_d = word_out;
          cnt_d      = cnt_q + 1'b1;
          prog_len_d = prog_len_q + 1'b1;
          // Terminator wins over overflow on the final slot.
          if (term)           state_d = DONE;
          else if (last_slot) state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prog_len_q <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prog_len_q <= prog_len_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  assign in_ready = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign prog_len = prog_len_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: driver feeds a program-level model, monitor checks every write.
module tb_instr_loader;
  localparam int VW  = 3;
  localparam int RW  = 4;
  localparam int DW  = 8;
  localparam int IW  = 4;
  localparam int IWD = 2 + VW + 2*RW + 3*DW;
`ifdef INSTR_LOADER_PARITY_EN
  localparam int WW = IWD + 1;
`else
  localparam int WW = IWD;
`endif
  localparam int DEPTH = 1 << IW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, in_ready;
  logic lstg_f = 1'b0, upse_f = 1'b0;
  logic [VW-1:0] vector_id = '0;
  logic [RW-1:0] result_reg = '0, error_reg = '0;
  logic [DW-1:0] data_uptr = '0, data_lptr = '0, coef_ptr = '0;
  logic          im_we;
  logic [IW-1:0] im_addr;
  logic [WW-1:0] im_wdata;
  logic          done, err;
  logic [IW:0]   prog_len;

  instr_loader #(.VIDWIDTH(VW), .RFAWIDTH(RW), .DAWIDTH(DW), .IAWIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .lstg_f(lstg_f), .upse_f(upse_f), .vector_id(vector_id), .result_reg(result_reg),
    .error_reg(error_reg), .data_uptr(data_uptr), .data_lptr(data_lptr), .coef_ptr(coef_ptr),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .done(done), .err(err),
    .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] addr;
    logic [WW-1:0] data;
    logic          dn;
    logic          er;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Program-level model: is a load open, how many words so far, sticky overflow, done pending.
  bit mdl_load = 0;
  bit mdl_done = 0;
  bit mdl_err  = 0;
  int mdl_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [WW-1:0] exp_word(input logic [IWD-1:0] f);
`ifdef INSTR_LOADER_PARITY_EN
    return {^f, f};
`else
    return f;
`endif
  endfunction

  function automatic logic [IWD-1:0] rnd_f(input bit term);
    logic [63:0] r;
    logic [IWD-1:0] f;
    r = {$urandom(), $urandom()};
    f = r[IWD-1:0];
    if (term) f[IWD-1:IWD-2] = 2'b11;
    else if (f[IWD-1] && f[IWD-2]) f[IWD-2] = 1'b0;
    return f;
  endfunction

  // One clock: drive inputs, advance model at the edge, check status outputs just after.
  task automatic step(input bit st, input bit v, input logic [IWD-1:0] f);
    exp_t e;
    bit   t;
    start    = st;
    in_valid = v;
    {lstg_f, upse_f, vector_id, result_reg, error_reg, data_uptr, data_lptr, coef_ptr} = f;
    t = f[IWD-1] && f[IWD-2];
    @(posedge clk);
    if (mdl_done) begin
      mdl_done = 0;
    end else if (mdl_load) begin
      if (v) begin
        e.addr = mdl_cnt[IW-1:0];
        e.data = exp_word(f);
        e.dn   = t;
        e.er   = !t && (mdl_cnt == DEPTH-1);
        exp_q.push_back(e);
        mdl_cnt++;
        if (t) begin
          mdl_load = 0;
          mdl_done = 1;
        end else if (mdl_cnt == DEPTH) begin
          mdl_load = 0;
          mdl_err  = 1;
        end
      end
    end else if (st) begin
      mdl_load = 1;
      mdl_cnt  = 0;
      mdl_err  = 0;
    end
    #1;
    chk("in_ready", in_ready, mdl_load);
    chk("prog_len", prog_len, mdl_cnt);
    chk("err", err, mdl_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  // Reset sampled at the edge, optionally while a word is being offered.
  task automatic reset_cycle(input bit v, input logic [IWD-1:0] f);
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = v;
    {lstg_f, upse_f, vector_id, result_reg, error_reg, data_uptr, data_lptr, coef_ptr} = f;
    @(posedge clk);
    mdl_load = 0; mdl_done = 0; mdl_err = 0; mdl_cnt = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_prog_len", prog_len, 0);
    rst = 1'b1;
  endtask

  // Monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {60'd0, im_addr}, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", im_addr, e.addr);
        chk("wr_data", im_wdata, e.data);
        chk("wr_done", done, e.dn);
        chk("wr_err", err, e.er);
      end
    end else if (rst === 1'b1) begin
      chk("done_without_write", done, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [IWD-1:0] f;
    logic [WW-1:0]  k;
    logic [IWD-1:0] nt;
    int             tp;

    reset_cycle(0, '0);
    reset_cycle(0, '0);
    idle(2);

    // Three-word program on consecutive cycles, terminator last.
    step(1, 0, '0);
    step(0, 1, rnd_f(0));
    step(0, 1, rnd_f(0));
    step(0, 1, rnd_f(1));
    idle(1);
    chk("prog3_len", prog_len, 3);
    idle(1);

    // Fixed field set: 1,0,101,1010,0011,80,10,FF packed MSB-first.
    nt = {1'b1, 1'b0, 3'd5, 4'hA, 4'h3, 8'h80, 8'h10, 8'hFF};
    step(1, 0, '0);
    step(0, 1, nt);
    @(negedge clk);
`ifdef INSTR_LOADER_PARITY_EN
    k = {1'b1, 37'h15A38010FF};
`else
    k = 37'h15A38010FF;
`endif
    chk("fixed_wdata", im_wdata, k);
    chk("fixed_addr", im_addr, 0);
    step(0, 1, rnd_f(1));
    idle(2);

    // Overflow: a full memory of non-terminators, then restart from ERR.
    step(1, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, rnd_f(0));
    chk("ovf_err", err, 1);
    chk("ovf_in_ready", in_ready, 0);
    chk("ovf_prog_len", prog_len, DEPTH);
    idle(2);
    step(1, 0, '0);
    chk("restart_err", err, 0);
    chk("restart_len", prog_len, 0);
    chk("restart_ready", in_ready, 1);
    // Terminator landing in the final slot completes normally.
    for (int i = 0; i < DEPTH-1; i++) step(0, 1, rnd_f(0));
    step(0, 1, rnd_f(1));
    chk("lastslot_done", done, 1);
    chk("lastslot_err", err, 0);
    idle(2);

    // Gapped valid: writes only on accepted cycles, addresses stay contiguous.
    step(1, 0, '0);
    step(0, 1, rnd_f(0));
    step(0, 0, rnd_f(1));
    step(0, 1, rnd_f(1));
    idle(2);
    chk("gap_len", prog_len, 2);

    // Reset while the second word is offered: only the first word is written.
    step(1, 0, '0);
    step(0, 1, rnd_f(0));
    reset_cycle(1, rnd_f(0));
    idle(3);

    // Randomized traffic including start pulses during LOAD/DONE.
    for (int ph = 0; ph < 8; ph++) begin
      tp = (ph % 2 == 0) ? 4 : 40;
      for (int c = 0; c < 120; c++) begin
        f = rnd_f($urandom_range(tp-1) == 0);
        step($urandom_range(7) == 0, $urandom_range(3) != 0, f);
      end
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
